fifo_wr_arbiter: RTL

//  Round-robin write-port arbiter for the shared 8-entry, 32-bit FIFO (fifo_2).

---
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, burst-limited arbiter sharing one FIFO write port
//            among N_REQ producers; stalls on FIFO full without rotating.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din_bus,
    input  logic                    fifo_full,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_din
);

    localparam int C_OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int C_CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [C_OWN_W-1:0] C_OWN_LAST = C_OWN_W'(N_REQ - 1);
    localparam logic [C_OWN_W-1:0] C_OWN_ONE  = C_OWN_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(MAX_BURST - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [N_REQ-1:0]   C_ONEHOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [N_REQ-1:0]     r_grant;
    logic [C_OWN_W-1:0]   r_owner;
    logic [C_OWN_W-1:0]   r_last_owner;
    logic [C_CNT_W-1:0]   r_burst_cnt;

    logic                 w_pick_valid;
    logic [C_OWN_W-1:0]   w_pick;
    logic [C_OWN_W-1:0]   w_scan;
    logic                 w_owner_req;
    logic                 w_wr;
    logic                 w_release;

    // Scan starts one past the previous owner so it ends up lowest priority.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        w_scan       = r_last_owner;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = (w_scan == C_OWN_LAST) ? '0 : w_scan + C_OWN_ONE;
            if (!w_pick_valid && req[w_scan]) begin
                w_pick_valid = 1'b1;
                w_pick       = w_scan;
            end
        end
    end

    assign w_owner_req = req[r_owner];
    // Reset suppresses the write in the very cycle it is asserted.
    assign w_wr        = (r_state == S_BUSY) & w_owner_req & ~fifo_full & en & ~rst;
    assign w_release   = (r_state == S_BUSY)
                       & ((w_wr & (r_burst_cnt == C_CNT_LAST)) | ~w_owner_req);

    assign fifo_wr_en = w_wr;
    assign ack        = w_wr ? r_grant : '0;
    assign grant      = r_grant;
    assign fifo_din   = din_bus[int'(r_owner)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= C_OWN_LAST;
            r_burst_cnt  <= '0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner     <= w_pick;
                        r_grant     <= C_ONEHOT0 << w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                        r_burst_cnt  <= '0;
                        r_state      <= S_IDLE;
                    end else if (w_wr) begin
                        r_burst_cnt <= r_burst_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
